// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard and stall controller for the RV32I 5-stage core
//
// Drives the enable/clear controls of the PC and the IF/ID, ID/EX, EX/MEM
// and MEM/WB pipeline registers. Arbitrates, highest priority first:
// reset, memory-timeout error, data-memory freeze, taken-branch flush,
// load-use stall, normal flow. Outputs are Mealy (current state + inputs).
//
// Ports:
//   clk_i, asynclr_i            clock, asynchronous active-high reset
//   id_rs1/rs2_addr_i, _used_i  source registers of the ID instruction
//   ex_rd_addr_i, ex_rd_wren_i  destination of the EX instruction
//   ex_wb_sel_i                 EX writeback select (WB_SEL_MEM = load)
//   ex_br_taken_i               EX branch/jump resolved taken
//   mem_req_i, mem_ready_i      MEM-stage data memory handshake
//   *_en_o, *_clr_o             pipeline register enables / bubble clears
//   stall/flush/freeze_cnt_o    wrapping event counters
//   err_o                       sticky memory timeout flag

module hazard_ctrl #(
  parameter logic [1:0] WB_SEL_MEM  = 2'b01,
  parameter int         MEM_TIMEOUT = 255,
  parameter int         CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             asynclr_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic [1:0]       ex_wb_sel_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_clr_o,
  output logic             id_ex_en_o,
  output logic             id_ex_clr_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_clr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o,
  output logic             err_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;

  logic freeze;
  logic load_use;
  logic flush_act;
  logic stall_act;

  // In WAIT the access is already outstanding, so mem_req_i is not re-checked.
  assign freeze = ((state_q == S_RUN)  && mem_req_i && !mem_ready_i) ||
                  ((state_q == S_WAIT) && !mem_ready_i);

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign load_use = ex_rd_wren_i && (ex_wb_sel_i == WB_SEL_MEM) &&
                    (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // A branch held in EX during a freeze fires on the release cycle; it also
  // wins over load-use because the ID instruction is on the wrong path.
  assign flush_act = (state_q != S_ERROR) && !freeze && ex_br_taken_i;
  assign stall_act = (state_q != S_ERROR) && !freeze && !ex_br_taken_i && load_use;

  always_ff @(posedge clk_i or posedge asynclr_i) begin
    if (asynclr_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (freeze) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready_i)                 state_d = S_RUN;
        else if (wait_cnt_q == WAIT_LAST) state_d = S_ERROR;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_en_o      = 1'b1;
    if_id_en_o   = 1'b1;
    if_id_clr_o  = 1'b0;
    id_ex_en_o   = 1'b1;
    id_ex_clr_o  = 1'b0;
    ex_mem_en_o  = 1'b1;
    mem_wb_clr_o = 1'b0;
    err_o        = 1'b0;
    if (asynclr_i) begin
      pc_en_o      = 1'b0;
      if_id_en_o   = 1'b0;
      id_ex_en_o   = 1'b0;
      ex_mem_en_o  = 1'b0;
      if_id_clr_o  = 1'b1;
      id_ex_clr_o  = 1'b1;
      mem_wb_clr_o = 1'b1;
    end else if (state_q == S_ERROR) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      err_o       = 1'b1;
    end else if (freeze) begin
      // Everything upstream of MEM holds; WB receives a bubble.
      pc_en_o      = 1'b0;
      if_id_en_o   = 1'b0;
      id_ex_en_o   = 1'b0;
      ex_mem_en_o  = 1'b0;
      mem_wb_clr_o = 1'b1;
    end else if (flush_act) begin
      if_id_clr_o = 1'b1;
      id_ex_clr_o = 1'b1;
    end else if (stall_act) begin
      // Hold PC and IF/ID, let a bubble into EX.
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_clr_o = 1'b1;
    end
  end

  // Counts consecutive freeze cycles; saturates rather than wrapping.
  always_ff @(posedge clk_i or posedge asynclr_i) begin
    if (asynclr_i) begin
      wait_cnt_q <= '0;
    end else if (state_d == S_RUN) begin
      wait_cnt_q <= '0;
    end else if (freeze && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge asynclr_i) begin
    if (asynclr_i) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      freeze_cnt_o <= '0;
    end else begin
      if (stall_act) stall_cnt_o  <= stall_cnt_o + CNT_W'(1);
      if (flush_act) flush_cnt_o  <= flush_cnt_o + CNT_W'(1);
      if (freeze)    freeze_cnt_o <= freeze_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        asynclr_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_rd_wren_i;
  logic [1:0]  ex_wb_sel_i;
  logic        ex_br_taken_i, mem_req_i, mem_ready_i;
  logic        pc_en_o, if_id_en_o, if_id_clr_o, id_ex_en_o, id_ex_clr_o;
  logic        ex_mem_en_o, mem_wb_clr_o, err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o, freeze_cnt_o;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.WB_SEL_MEM(2'b01), .MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk_i(clk_i), .asynclr_i(asynclr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wren_i(ex_rd_wren_i),
    .ex_wb_sel_i(ex_wb_sel_i), .ex_br_taken_i(ex_br_taken_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_clr_o(if_id_clr_o),
    .id_ex_en_o(id_ex_en_o), .id_ex_clr_o(id_ex_clr_o),
    .ex_mem_en_o(ex_mem_en_o), .mem_wb_clr_o(mem_wb_clr_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .freeze_cnt_o(freeze_cnt_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pipeline mode flags plus plain integer counts.
  bit          m_waiting, m_errored;
  int          m_waits;
  int unsigned m_stall, m_flush, m_freeze;

  // Control vector order: pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, mem_wb_clr
  localparam logic [6:0] V_RESET  = 7'b0010101;
  localparam logic [6:0] V_ERROR  = 7'b0000000;
  localparam logic [6:0] V_FREEZE = 7'b0000001;
  localparam logic [6:0] V_FLUSH  = 7'b1111110;
  localparam logic [6:0] V_STALL  = 7'b0001110;
  localparam logic [6:0] V_NORMAL = 7'b1101010;

  function automatic bit m_hazard();
    bit is_load = ex_rd_wren_i && ex_wb_sel_i == 2'b01 && ex_rd_addr_i != 0;
    bit reads   = (id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
                  (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i);
    return is_load && reads;
  endfunction

  function automatic bit m_frozen();
    return m_waiting ? !mem_ready_i : (mem_req_i && !mem_ready_i);
  endfunction

  function automatic logic [6:0] m_ctrl();
    if (m_errored)     return V_ERROR;
    if (m_frozen())    return V_FREEZE;
    if (ex_br_taken_i) return V_FLUSH;
    if (m_hazard())    return V_STALL;
    return V_NORMAL;
  endfunction

  task automatic m_clock();
    if (m_errored) return;
    if (m_frozen()) begin
      m_freeze++;
      if (m_waiting && m_waits == T - 1) m_errored = 1;
      else begin
        m_waiting = 1;
        m_waits++;
      end
    end else begin
      m_waiting = 0;
      m_waits   = 0;
      if (ex_br_taken_i)   m_flush++;
      else if (m_hazard()) m_stall++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dut_ctrl();
    return {pc_en_o, if_id_en_o, if_id_clr_o, id_ex_en_o, id_ex_clr_o, ex_mem_en_o, mem_wb_clr_o};
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ctrl"},   {25'd0, dut_ctrl()}, {25'd0, m_ctrl()});
    check({tag, ".err"},    {31'd0, err_o},      {31'd0, m_errored});
    check({tag, ".stall"},  stall_cnt_o,         m_stall);
    check({tag, ".flush"},  flush_cnt_o,         m_flush);
    check({tag, ".freeze"}, freeze_cnt_o,        m_freeze);
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic wren,
                        input logic [1:0] wbsel, input logic br, input logic req,
                        input logic rdy);
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    id_rs1_used_i = u1;  id_rs2_used_i = u2;
    ex_rd_addr_i  = rd;  ex_rd_wren_i  = wren; ex_wb_sel_i = wbsel;
    ex_br_taken_i = br;  mem_req_i     = req;  mem_ready_i = rdy;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk_i);
    m_clock();
    @(negedge clk_i);
  endtask

  // Asserts reset mid-low-phase so its effect is visible without a clock edge.
  task automatic do_reset(input string tag);
    #2;
    asynclr_i = 1'b1;
    #1;
    m_waiting = 0; m_errored = 0; m_waits = 0;
    m_stall = 0; m_flush = 0; m_freeze = 0;
    check({tag, ".rst_ctrl"},   {25'd0, dut_ctrl()}, {25'd0, V_RESET});
    check({tag, ".rst_err"},    {31'd0, err_o},      32'd0);
    check({tag, ".rst_cnt"},    stall_cnt_o | flush_cnt_o | freeze_cnt_o, 32'd0);
    @(negedge clk_i);
    asynclr_i = 1'b0;
  endtask

  initial begin
    asynclr_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    do_reset("init");

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("idle");

    // Load to x5 in EX, add using x5 in ID, then the bubble.
    set_in(5, 7, 1, 1, 5, 1, 2'b01, 0, 0, 1);
    step("lu");
    set_in(5, 7, 1, 1, 0, 0, 2'b00, 0, 0, 1);
    step("lu_bubble");
    check("lu_stall_one", stall_cnt_o, 32'd1);

    // rs2 match also stalls; a non-load (wb_sel=00) does not.
    set_in(1, 9, 0, 1, 9, 1, 2'b01, 0, 0, 1);
    step("lu_rs2");
    set_in(9, 9, 1, 1, 9, 1, 2'b00, 0, 0, 1);
    step("alu_fwd");

    // Branch overrides load-use.
    do_reset("br");
    set_in(5, 0, 1, 0, 5, 1, 2'b01, 1, 0, 1);
    step("br_lu");
    check("br_flush_one", flush_cnt_o, 32'd1);
    check("br_stall_zero", stall_cnt_o, 32'd0);

    // Three not-ready cycles then ready.
    do_reset("frz");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step("frz_on");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("frz_rel");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("frz_after");
    check("frz_three", freeze_cnt_o, 32'd3);

    // Branch held across a two-cycle freeze flushes on release.
    do_reset("brf");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (2) step("brf_hold");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("brf_rel");
    check("brf_flush_one", flush_cnt_o, 32'd1);

    // Timeout with ready stuck low.
    do_reset("to");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (T) step("to_wait");
    check("to_err_set", {31'd0, err_o}, 32'd1);
    check("to_freeze_n", freeze_cnt_o, T);
    set_in(5, 0, 1, 0, 5, 1, 2'b01, 1, 1, 1);
    repeat (2) step("to_sticky");
    do_reset("to_clr");

    // Load to x0 never stalls.
    set_in(0, 0, 1, 1, 0, 1, 2'b01, 0, 0, 1);
    step("x0");
    check("x0_no_stall", stall_cnt_o, 32'd0);

    // Random traffic with a narrow register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset("rnd_rst");
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
